// File: rtl/csr_pkg.sv
// CSR trap controller shared definitions: CSR addresses, mstatus bit
// positions, privilege mode encodings, cause codes and sequencer states.
package csr_pkg;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MTVAL   = 12'h343;

   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;

   localparam logic [1:0] MODE_U = 2'b00;
   localparam logic [1:0] MODE_S = 2'b01;
   localparam logic [1:0] MODE_M = 2'b11;

   localparam int CAUSE_ILLEGAL = 2;
   localparam int CAUSE_MEI     = 11;

   typedef enum logic [2:0] {
      TS_IDLE    = 3'd0,
      TS_EPC     = 3'd1,
      TS_CAUSE   = 3'd2,
      TS_TVAL    = 3'd3,
      TS_STATUS  = 3'd4,
      TS_RSTATUS = 3'd5
   } trap_state_e;

endpackage

// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl: owns the CSR regfile write port. In IDLE it passes
// instruction CSR writes through; on a trap it writes mepc, mcause, mtval
// and mstatus on consecutive cycles, then redirects to the trap vector.
// A legal mret does one mstatus write plus a redirect to mepc.
// Optional feature macro: VECTORED_MTVEC_EN (vectored interrupt dispatch).
//
// Handshake: csr_wr_req is a valid with no backpressure hold; csr_wr_grant
// is a same-cycle ready. A request that is not granted is not remembered,
// the pipeline is stalled (or flushed by the trap) and must re-present it.
module csr_trap_ctrl
   import csr_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int CAUSE_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               csr_wr_req,
   input  logic [11:0]        csr_wr_addr,
   input  logic [XLEN-1:0]    csr_wr_data,
   output logic               csr_wr_grant,
   input  logic               exc_valid,
   input  logic [CAUSE_W-1:0] exc_cause,
   input  logic [XLEN-1:0]    exc_pc,
   input  logic [XLEN-1:0]    exc_tval,
   input  logic               irq_valid,
   input  logic [XLEN-1:0]    irq_pc,
   input  logic               mret,
   input  logic [XLEN-1:0]    mtvec_val,
   input  logic [XLEN-1:0]    mepc_val,
   input  logic [XLEN-1:0]    mstatus_val,
   output logic               rf_we,
   output logic [11:0]        rf_waddr,
   output logic [XLEN-1:0]    rf_wdata,
   output logic               stall,
   output logic               redirect_valid,
   output logic [XLEN-1:0]    redirect_pc,
   output logic [1:0]         current_mode
);

   localparam logic [2:0] S_IDLE    = TS_IDLE;
   localparam logic [2:0] S_EPC     = TS_EPC;
   localparam logic [2:0] S_CAUSE   = TS_CAUSE;
   localparam logic [2:0] S_TVAL    = TS_TVAL;
   localparam logic [2:0] S_STATUS  = TS_STATUS;
   localparam logic [2:0] S_RSTATUS = TS_RSTATUS;

   localparam logic [XLEN-1:0] IRQ_CAUSE =
      {1'b1, {(XLEN-1-CAUSE_W){1'b0}}, CAUSE_W'(CAUSE_MEI)};

   logic [2:0]      state, state_nxt;
   logic [1:0]      mode_nxt;
   logic [XLEN-1:0] cap_pc, cap_cause, cap_tval;
   logic            cap_irq;

   logic            is_idle, irq_en, illegal_mret;
   logic            take_exc, take_ill, take_irq, take_mret;
   logic [XLEN-1:0] trap_base, trap_vec, status_trap, status_ret;

   assign is_idle      = (state == S_IDLE);
   assign irq_en       = mstatus_val[MSTATUS_MIE] | (current_mode != MODE_M);
   assign illegal_mret = mret & (current_mode != MODE_M);

   // Event priority: exception > illegal mret > interrupt > legal mret.
   assign take_exc  = is_idle & exc_valid;
   assign take_ill  = is_idle & ~exc_valid & illegal_mret;
   assign take_irq  = is_idle & ~exc_valid & ~illegal_mret & irq_valid & irq_en;
   assign take_mret = is_idle & ~exc_valid & ~illegal_mret & ~take_irq & mret;

   assign trap_base = {mtvec_val[XLEN-1:2], 2'b00};

`ifdef VECTORED_MTVEC_EN
   // Interrupts in vectored mode land at base + 4*code; exceptions at base.
   assign trap_vec = (mtvec_val[1:0] == 2'b01 && cap_irq) ?
      trap_base + {{(XLEN-CAUSE_W-2){1'b0}}, cap_cause[CAUSE_W-1:0], 2'b00} :
      trap_base;
`else
   logic unused_bits;
   assign unused_bits = ^{mtvec_val[1:0], cap_irq};
   assign trap_vec    = trap_base;
`endif

   // mstatus read-modify-write images for trap entry and mret.
   always_comb begin
      status_trap = mstatus_val;
      status_trap[MSTATUS_MPIE] = mstatus_val[MSTATUS_MIE];
      status_trap[MSTATUS_MIE]  = 1'b0;
      status_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = current_mode;
      status_ret = mstatus_val;
      status_ret[MSTATUS_MIE]  = mstatus_val[MSTATUS_MPIE];
      status_ret[MSTATUS_MPIE] = 1'b1;
      status_ret[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = MODE_U;
   end

   // Write-port arbitration, sequencer next state, redirect and stall.
   always_comb begin
      rf_we          = 1'b0;
      rf_waddr       = 12'h000;
      rf_wdata       = '0;
      csr_wr_grant   = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      stall          = 1'b0;
      state_nxt      = state;
      mode_nxt       = current_mode;
      if (!rst) begin
         stall = ~is_idle | exc_valid | mret | take_irq;
         case (state)
            S_IDLE: begin
               if (take_exc || take_ill || take_irq) begin
                  state_nxt = S_EPC;
               end else if (take_mret) begin
                  state_nxt = S_RSTATUS;
               end else if (csr_wr_req) begin
                  csr_wr_grant = 1'b1;
                  rf_we        = 1'b1;
                  rf_waddr     = csr_wr_addr;
                  rf_wdata     = csr_wr_data;
               end
            end
            S_EPC: begin
               rf_we     = 1'b1;
               rf_waddr  = CSR_MEPC;
               rf_wdata  = cap_pc;
               state_nxt = S_CAUSE;
            end
            S_CAUSE: begin
               rf_we     = 1'b1;
               rf_waddr  = CSR_MCAUSE;
               rf_wdata  = cap_cause;
               state_nxt = S_TVAL;
            end
            S_TVAL: begin
               rf_we     = 1'b1;
               rf_waddr  = CSR_MTVAL;
               rf_wdata  = cap_tval;
               state_nxt = S_STATUS;
            end
            S_STATUS: begin
               rf_we          = 1'b1;
               rf_waddr       = CSR_MSTATUS;
               rf_wdata       = status_trap;
               redirect_valid = 1'b1;
               redirect_pc    = trap_vec;
               mode_nxt       = MODE_M;
               state_nxt      = S_IDLE;
            end
            S_RSTATUS: begin
               rf_we          = 1'b1;
               rf_waddr       = CSR_MSTATUS;
               rf_wdata       = status_ret;
               redirect_valid = 1'b1;
               redirect_pc    = mepc_val;
               mode_nxt       = mstatus_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
               state_nxt      = S_IDLE;
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // State and privilege mode registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         current_mode <= MODE_M;
      end else begin
         state        <= state_nxt;
         current_mode <= mode_nxt;
      end
   end

   // Capture trap pc/cause/tval in the accept cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         cap_pc    <= '0;
         cap_cause <= '0;
         cap_tval  <= '0;
         cap_irq   <= 1'b0;
      end else if (take_exc) begin
         cap_pc    <= exc_pc;
         cap_cause <= {{(XLEN-CAUSE_W){1'b0}}, exc_cause};
         cap_tval  <= exc_tval;
         cap_irq   <= 1'b0;
      end else if (take_ill) begin
         cap_pc    <= exc_pc;
         cap_cause <= XLEN'(CAUSE_ILLEGAL);
         cap_tval  <= '0;
         cap_irq   <= 1'b0;
      end else if (take_irq) begin
         cap_pc    <= irq_pc;
         cap_cause <= IRQ_CAUSE;
         cap_tval  <= '0;
         cap_irq   <= 1'b1;
      end
   end

endmodule
